// File: rtl/display_pkg.sv
// Shared display definitions: transmit FSM encoding and default digit geometry,
// common to the segment encoder and the frame serializer.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } tx_state_t;

    localparam int DEF_SEG_BITS   = 8;
    localparam int DEF_NUM_DIGITS = 6;

endpackage

// File: rtl/seg_frame_serializer_sr_bit_timer.sv
// Serial bit timer: a divider that produces the serial-clock phase and a
// per-bit tick, plus a bit counter that flags the last bit of a frame.
module sr_bit_timer #(
    parameter int N_BITS  = 48,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sclk_phase,
    output logic bit_tick,
    output logic frame_done
);

    localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
    localparam int BIT_W = $clog2(N_BITS) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    // Low half of the bit period first, so data settles before the rising edge.
    assign sclk_phase = (div_cnt >= DIV_HALF);
    assign bit_tick   = en & (div_cnt == DIV_LAST);
    assign frame_done = bit_tick & (bit_cnt == BIT_LAST);

    // Divider wraps at the terminal count and bumps the bit counter; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_frame_serializer.sv
// Frame serializer for daisy-chained display shift registers: one-frame
// holding buffer behind a valid/ready handshake, MSB-first shift-out with a
// divided serial clock, a latch pulse per frame and optional auto-refresh.
module seg_frame_serializer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int SEG_BITS   = DEF_SEG_BITS,
    parameter int CLK_DIV    = 2,
    parameter int REFRESH    = 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_en,
    input  logic [NUM_DIGITS*SEG_BITS-1:0] i_frame,
    input  logic                           i_frame_valid,
    output logic                           o_frame_ready,
    output logic                           o_serial_data,
    output logic                           o_serial_clk,
    output logic                           o_serial_latch,
    output logic                           o_busy
);

    localparam int N_BITS = NUM_DIGITS * SEG_BITS;

    tx_state_t state, state_nxt;

    logic [N_BITS-1:0] hold_reg;
    logic [N_BITS-1:0] shift_reg;
    logic              hold_full;
    logic              loaded;

    logic load_shift;
    logic take_hold;
    logic tmr_clr;
    logic tmr_en;
    logic sclk_phase;
    logic bit_tick;
    logic frame_done;
    logic accept;

    assign accept = i_frame_valid & ~hold_full;

    sr_bit_timer #(
        .N_BITS  (N_BITS),
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .clr        (tmr_clr),
        .en         (tmr_en),
        .sclk_phase (sclk_phase),
        .bit_tick   (bit_tick),
        .frame_done (frame_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; a pending frame beats a refresh.
    always_comb begin
        state_nxt  = state;
        load_shift = 1'b0;
        take_hold  = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (i_en && hold_full) begin
                    load_shift = 1'b1;
                    take_hold  = 1'b1;
                    state_nxt  = ST_SHIFT;
                end else if (i_en && (REFRESH != 0) && loaded) begin
                    load_shift = 1'b1;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                tmr_en = i_en;
                if (frame_done) begin
                    tmr_clr   = 1'b1;
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // The divider times one full bit period for the latch pulse.
                tmr_en = i_en;
                if (bit_tick) begin
                    tmr_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                tmr_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding buffer: content is kept after transfer so refresh can resend it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            loaded    <= 1'b0;
        end else if (accept) begin
            hold_reg  <= i_frame;
            hold_full <= 1'b1;
            loaded    <= 1'b1;
        end else if (take_hold) begin
            hold_full <= 1'b0;
        end
    end

    // Shift register: loads from the buffer, shifts left at each bit boundary.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            shift_reg <= '0;
        end else if (load_shift) begin
            shift_reg <= hold_reg;
        end else if ((state == ST_SHIFT) && bit_tick) begin
            shift_reg <= shift_reg << 1;
        end
    end

    assign o_frame_ready  = ~hold_full;
    assign o_serial_data  = (state == ST_SHIFT) & shift_reg[N_BITS-1];
    assign o_serial_clk   = (state == ST_SHIFT) & sclk_phase;
    assign o_serial_latch = (state == ST_LATCH);
    assign o_busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_seg_frame_serializer.sv
// Bench for seg_frame_serializer: three instances (default no-refresh,
// default with refresh, 4x7 bits at CLK_DIV=1) observed through one selector.
module tb_seg_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a;
    logic [47:0] frame_a, frame_b;
    logic [27:0] frame_c;
    logic        valid_a, valid_b, valid_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        dat_a, dat_b, dat_c;
    logic        sck_a, sck_b, sck_c;
    logic        lat_a, lat_b, lat_c;
    logic        bsy_a, bsy_b, bsy_c;

    seg_frame_serializer #(.NUM_DIGITS(6), .SEG_BITS(8), .CLK_DIV(2), .REFRESH(0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en_a), .i_frame(frame_a),
        .i_frame_valid(valid_a), .o_frame_ready(rdy_a), .o_serial_data(dat_a),
        .o_serial_clk(sck_a), .o_serial_latch(lat_a), .o_busy(bsy_a));

    seg_frame_serializer #(.NUM_DIGITS(6), .SEG_BITS(8), .CLK_DIV(2), .REFRESH(1)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(1'b1), .i_frame(frame_b),
        .i_frame_valid(valid_b), .o_frame_ready(rdy_b), .o_serial_data(dat_b),
        .o_serial_clk(sck_b), .o_serial_latch(lat_b), .o_busy(bsy_b));

    seg_frame_serializer #(.NUM_DIGITS(4), .SEG_BITS(7), .CLK_DIV(1), .REFRESH(0)) dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(1'b1), .i_frame(frame_c),
        .i_frame_valid(valid_c), .o_frame_ready(rdy_c), .o_serial_data(dat_c),
        .o_serial_clk(sck_c), .o_serial_latch(lat_c), .o_busy(bsy_c));

    int   sel;
    logic mon_data, mon_sclk, mon_latch, mon_busy, mon_ready;

    always_comb begin
        case (sel)
            0:       {mon_data, mon_sclk, mon_latch, mon_busy, mon_ready} = {dat_a, sck_a, lat_a, bsy_a, rdy_a};
            1:       {mon_data, mon_sclk, mon_latch, mon_busy, mon_ready} = {dat_b, sck_b, lat_b, bsy_b, rdy_b};
            default: {mon_data, mon_sclk, mon_latch, mon_busy, mon_ready} = {dat_c, sck_c, lat_c, bsy_c, rdy_c};
        endcase
    end

    int total = 0;
    int bad   = 0;

    logic [127:0] cap;
    int           nbits, nones, npulse, lw_cur, lw_last, t_idle, t_busy2, freeze_bad;
    logic         first_data, first_busy;
    int           lf[4];
    int           nbl[4];
    logic [47:0]  capl[4];

    typedef struct {
        logic [47:0] frame;
        int          ones;
        logic        first;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Offer one frame to the selected instance; returns at the negedge after acceptance.
    task automatic send(input int s, input logic [47:0] f);
        int w;
        w = 0;
        @(negedge clk);
        while (!mon_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready", 128'(mon_ready), 128'(1));
        case (s)
            0:       begin frame_a = f;        valid_a = 1'b1; end
            1:       begin frame_b = f;        valid_b = 1'b1; end
            default: begin frame_c = f[27:0];  valid_c = 1'b1; end
        endcase
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    // Sample the selected instance once per cycle on the falling edge.
    task automatic observe(input int ncyc, input bit stop_idle, input int drop_at, input int drop_len);
        logic       p_sclk, p_latch, seen;
        logic [4:0] cur, snap;
        cap = '0; nbits = 0; nones = 0; npulse = 0; lw_cur = 0; lw_last = 0;
        t_idle = 0; t_busy2 = 0; freeze_bad = 0; first_data = 1'b0; first_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lf[i] = 0; nbl[i] = 0; capl[i] = '0;
        end
        snap = '0;
        p_sclk = mon_sclk;
        p_latch = mon_latch;
        seen = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            cur = {mon_data, mon_sclk, mon_latch, mon_busy, mon_ready};
            if (k == 1) begin
                first_data = mon_data;
                first_busy = mon_busy;
            end
            if (mon_sclk && !p_sclk) begin
                cap = {cap[126:0], mon_data};
                nbits++;
                if (mon_data) nones++;
            end
            if (mon_latch) lw_cur++;
            if (!mon_latch && p_latch) begin
                if (npulse < 4) begin
                    lf[npulse]   = k;
                    capl[npulse] = cap[47:0];
                    nbl[npulse]  = nbits;
                end
                npulse++;
                lw_last = lw_cur;
                lw_cur  = 0;
            end
            if (mon_busy && t_idle != 0 && t_busy2 == 0) t_busy2 = k;
            if (mon_busy) seen = 1'b1;
            if (seen && !mon_busy && t_idle == 0) t_idle = k;
            if (drop_len > 0) begin
                if (k == drop_at) begin
                    snap = cur;
                    en_a = 1'b0;
                end else if (k > drop_at && k <= drop_at + drop_len) begin
                    if (cur !== snap) freeze_bad++;
                    if (k == drop_at + drop_len) en_a = 1'b1;
                end
            end
            p_sclk  = mon_sclk;
            p_latch = mon_latch;
            if (stop_idle && t_idle != 0) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{48'hFF00_0000_00A5, 12, 1'b1};
        vecs[1] = '{48'h1234_5678_9ABC, 22, 1'b0};
        vecs[2] = '{48'h8000_0000_0001,  2, 1'b1};
        vecs[3] = '{48'h0000_0000_0000,  0, 1'b0};
        vecs[4] = '{48'hFFFF_FFFF_FFFF, 48, 1'b1};

        sel = 0; rst_n = 1'b0; en_a = 1'b1;
        frame_a = '0; frame_b = '0; frame_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", 128'({mon_data, mon_sclk, mon_latch, mon_busy, mon_ready}), 128'(5'b00001));
        sel = 2;
        #1;
        chk("reset_outputs_c", 128'({mon_data, mon_sclk, mon_latch, mon_busy, mon_ready}), 128'(5'b00001));
        sel = 0;
        rst_n = 1'b1;

        // Single frames, one per table row.
        for (int i = 0; i < 5; i++) begin
            send(0, vecs[i].frame);
            observe(400, 1'b1, 0, 0);
            chk($sformatf("v%0d_bits", i),    128'(cap[47:0]), 128'(vecs[i].frame));
            chk($sformatf("v%0d_nbits", i),   128'(nbits), 128'(48));
            chk($sformatf("v%0d_ones", i),    128'(nones), 128'(vecs[i].ones));
            chk($sformatf("v%0d_period", i),  128'(t_idle), 128'(197));
            chk($sformatf("v%0d_latchw", i),  128'(lw_last), 128'(4));
            chk($sformatf("v%0d_npulse", i),  128'(npulse), 128'(1));
            chk($sformatf("v%0d_first", i),   128'(first_data), 128'(vecs[i].first));
            chk($sformatf("v%0d_busy_t1", i), 128'(first_busy), 128'(1));
        end
        observe(100, 1'b0, 0, 0);
        chk("quiet_bits",   128'(nbits), 128'(0));
        chk("quiet_pulses", 128'(npulse), 128'(0));

        // Back-to-back: B held valid while A is taken, then sent after one IDLE cycle.
        @(negedge clk);
        frame_a = 48'hC3C3_5A5A_0F0F; valid_a = 1'b1;
        @(negedge clk);
        chk("b2b_ready_t", 128'(mon_ready), 128'(0));
        frame_a = 48'h0123_4567_89AB;
        @(negedge clk);
        chk("b2b_ready_t1", 128'(mon_ready), 128'(1));
        @(negedge clk);
        chk("b2b_ready_t2", 128'(mon_ready), 128'(0));
        valid_a = 1'b0;
        observe(420, 1'b0, 0, 0);
        chk("b2b_bits",   cap[95:0], {48'hC3C3_5A5A_0F0F, 48'h0123_4567_89AB});
        chk("b2b_nbits",  128'(nbits), 128'(96));
        chk("b2b_pulses", 128'(npulse), 128'(2));
        chk("b2b_idle_a", 128'(t_idle), 128'(195));
        chk("b2b_gap",    128'(t_busy2), 128'(196));
        chk("b2b_latch2", 128'(lf[1]), 128'(392));

        // Enable dropped for 10 cycles in the middle of bit 20.
        send(0, 48'h5A5A_F0F0_3C3C);
        observe(400, 1'b1, 82, 10);
        chk("endrop_frozen", 128'(freeze_bad), 128'(0));
        chk("endrop_bits",   128'(cap[47:0]), 128'(48'h5A5A_F0F0_3C3C));
        chk("endrop_period", 128'(t_idle), 128'(207));
        chk("endrop_npulse", 128'(npulse), 128'(1));

        // Auto-refresh repeats the last frame every period.
        sel = 1;
        send(1, 48'h1234_5678_9ABC);
        observe(600, 1'b0, 0, 0);
        chk("ref_npulse", 128'(npulse), 128'(3));
        chk("ref_first",  128'(lf[0]), 128'(197));
        chk("ref_per1",   128'(lf[1] - lf[0]), 128'(197));
        chk("ref_per2",   128'(lf[2] - lf[1]), 128'(197));
        chk("ref_cap0",   128'(capl[0]), 128'(48'h1234_5678_9ABC));
        chk("ref_cap1",   128'(capl[1]), 128'(48'h1234_5678_9ABC));
        chk("ref_cap2",   128'(capl[2]), 128'(48'h1234_5678_9ABC));
        chk("ref_nbits",  128'(nbl[2]), 128'(144));
        chk("ref_latchw", 128'(lw_last), 128'(4));

        // Reset in the middle of bit 30 aborts the frame without a latch pulse.
        sel = 0;
        send(0, 48'hDEAD_BEEF_CAFE);
        repeat (122) @(negedge clk);
        chk("rst_busy_before", 128'(mon_busy), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 128'({mon_data, mon_sclk, mon_latch, mon_busy, mon_ready}), 128'(5'b00001));
        rst_n = 1'b1;
        observe(250, 1'b0, 0, 0);
        chk("rst_no_latch", 128'(npulse), 128'(0));
        chk("rst_no_bits",  128'(nbits), 128'(0));
        send(0, 48'h0F1E_2D3C_4B5A);
        observe(400, 1'b1, 0, 0);
        chk("rst_after_bits",   128'(cap[47:0]), 128'(48'h0F1E_2D3C_4B5A));
        chk("rst_after_period", 128'(t_idle), 128'(197));

        // 4 digits x 7 bits at CLK_DIV=1.
        sel = 2;
        send(2, 48'h0000_09A5_C3E1);
        observe(200, 1'b1, 0, 0);
        chk("sweep_bits",   128'(cap[27:0]), 128'(28'h9A5C3E1));
        chk("sweep_nbits",  128'(nbits), 128'(28));
        chk("sweep_period", 128'(t_idle), 128'(59));
        chk("sweep_latchw", 128'(lw_last), 128'(2));
        chk("sweep_npulse", 128'(npulse), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
